// File: rtl/pulse_bank.sv
// Bank of independent pulse channels driven by a shared quarter/half-frame sequencer.
// Each channel has a duty sequencer, length counter and decay envelope; volumes are summed.
module pulse_bank #(
  parameter int NUM_CH  = 4,
  parameter int TIMER_W = 11,
  parameter int QFR_DIV = 20,
  localparam int AW    = $clog2(NUM_CH) + 2,
  localparam int OUT_W = 4 + $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [7:0]          wr_data,
  output logic [4*NUM_CH-1:0] ch_out,
  output logic [OUT_W-1:0]    mix_out,
  output logic                qfr_tick,
  output logic                hfr_tick
);

  localparam int DIV_W = (QFR_DIV > 1) ? $clog2(QFR_DIV) : 1;

  logic [DIV_W-1:0] div_reg;
  logic             hfr_phase_reg;
  logic             qfr_tick_reg;
  logic             hfr_tick_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg       <= '0;
      hfr_phase_reg <= 1'b0;
      qfr_tick_reg  <= 1'b0;
      hfr_tick_reg  <= 1'b0;
    end else if (div_reg == DIV_W'(QFR_DIV - 1)) begin
      // Half-frame rides on every second quarter-frame, starting with the second.
      div_reg       <= '0;
      qfr_tick_reg  <= 1'b1;
      hfr_tick_reg  <= hfr_phase_reg;
      hfr_phase_reg <= ~hfr_phase_reg;
    end else begin
      div_reg       <= div_reg + DIV_W'(1);
      qfr_tick_reg  <= 1'b0;
      hfr_tick_reg  <= 1'b0;
    end
  end

  assign qfr_tick = qfr_tick_reg;
  assign hfr_tick = hfr_tick_reg;

  logic [AW-1:0] wr_ch;
  logic [3:0]    ch_vol [NUM_CH];

  assign wr_ch = wr_addr >> 2;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [7:0]         bank_reg [4];
    logic [TIMER_W-1:0] timer_reg;
    logic [2:0]         step_reg;
    logic [6:0]         length_reg;
    logic               start_reg;
    logic [3:0]         decay_reg;
    logic [3:0]         env_div_reg;

    logic               wr_hit;
    logic               wr_len;
    logic [1:0]         duty;
    logic               halt_loop;
    logic               const_vol;
    logic [3:0]         vol;
    logic               enable;
    logic [TIMER_W-1:0] period;
    logic [7:0]         duty_pat;
    logic               seq_bit;
    logic               unused_bits;

    assign wr_hit      = wr_en && (wr_ch == AW'(gi));
    assign wr_len      = wr_hit && (wr_addr[1:0] == 2'd3);
    assign duty        = bank_reg[0][7:6];
    assign halt_loop   = bank_reg[0][5];
    assign const_vol   = bank_reg[0][4];
    assign vol         = bank_reg[0][3:0];
    assign enable      = bank_reg[1][0];
    assign period      = {bank_reg[3][TIMER_W-9:0], bank_reg[2]};
    assign unused_bits = ^bank_reg[1][7:1];

    // Bit n of the pattern is the output of sequencer step n.
    always_comb begin
      duty_pat = 8'b0000_0010;
      case (duty)
        2'd0: duty_pat = 8'b0000_0010;
        2'd1: duty_pat = 8'b0000_0110;
        2'd2: duty_pat = 8'b0001_1110;
        2'd3: duty_pat = 8'b1111_1001;
        default: duty_pat = 8'b0000_0010;
      endcase
    end

    assign seq_bit = duty_pat[step_reg];

    assign ch_vol[gi] = (enable && (length_reg != 7'd0) && (period >= TIMER_W'(8)) && seq_bit)
                        ? (const_vol ? vol : decay_reg) : 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) begin
          bank_reg[i] <= '0;
        end
        timer_reg   <= '0;
        step_reg    <= '0;
        length_reg  <= '0;
        start_reg   <= 1'b0;
        decay_reg   <= '0;
        env_div_reg <= '0;
      end else begin
        if (wr_hit) begin
          bank_reg[wr_addr[1:0]] <= wr_data;
        end

        // Reload reads the period before any write landing on this edge.
        if (timer_reg == '0) begin
          timer_reg <= period;
          step_reg  <= step_reg + 3'd1;
        end else begin
          timer_reg <= timer_reg - TIMER_W'(1);
        end

        if (wr_len) begin
          step_reg   <= 3'd0;
          length_reg <= {1'b0, wr_data[7:3], 1'b0} + 7'd2;
        end else if (hfr_tick_reg && (length_reg != 7'd0) && !halt_loop) begin
          length_reg <= length_reg - 7'd1;
        end

        if (qfr_tick_reg) begin
          if (start_reg) begin
            decay_reg   <= 4'd15;
            env_div_reg <= vol;
            start_reg   <= 1'b0;
          end else if (env_div_reg == 4'd0) begin
            env_div_reg <= vol;
            if (decay_reg != 4'd0) begin
              decay_reg <= decay_reg - 4'd1;
            end else if (halt_loop) begin
              decay_reg <= 4'd15;
            end
          end else begin
            env_div_reg <= env_div_reg - 4'd1;
          end
        end

        if (wr_len) begin
          start_reg <= 1'b1;
        end
      end
    end
  end

  logic [4*NUM_CH-1:0] ch_out_next;
  logic [4*NUM_CH-1:0] ch_out_reg;
  logic [OUT_W-1:0]    mix_next;
  logic [OUT_W-1:0]    mix_out_reg;

  always_comb begin
    ch_out_next = '0;
    mix_next    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_out_next[4*i +: 4] = ch_vol[i];
      mix_next              = mix_next + OUT_W'(ch_vol[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_out_reg  <= '0;
      mix_out_reg <= '0;
    end else begin
      ch_out_reg  <= ch_out_next;
      mix_out_reg <= mix_next;
    end
  end

  assign ch_out  = ch_out_reg;
  assign mix_out = mix_out_reg;

endmodule
